// File: rtl/face_pkg.sv
// Shared definitions for the face creator / face timer pair: FSM state
// encoding, the blank digit pattern and the default board tick rate.
package face_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT    = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int DEFAULT_CLK_PER_MS = 50000;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts clk cycles and raises tick for one cycle on
// the terminal count. clear holds the count at zero and suppresses tick.
module ms_tick_gen
  import face_pkg::*;
#(
  parameter int CLK_PER_MS = DEFAULT_CLK_PER_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLK_PER_MS) + 1;
  localparam logic [W-1:0] TERM = W'(CLK_PER_MS - 1);

  logic [W-1:0] cnt;

  assign tick = !clear && (cnt == TERM);

  // Prescaler: restart on reset, clear or terminal count, otherwise advance.
  always_ff @(posedge clk) begin
    if (!rst || clear || (cnt == TERM))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/face_timer_display.sv
// Face timer responder and 7-seg display mux.
// Times the face hold period after timer_enable, returns a one-cycle timeout
// pulse, and overlays the eyes/mouth face on the game digits when showFace.
// Optional eye blinking is enabled by defining FACE_BLINK_EN.
module face_timer_display
  import face_pkg::*;
#(
  parameter int CLK_PER_MS = DEFAULT_CLK_PER_MS,
  parameter int HOLD_MS    = 2000,
  parameter int BLINK_MS   = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_enable,
  input  logic        showFace,
  input  logic [6:0]  eyes,
  input  logic [6:0]  mouth,
  input  logic [27:0] game_seg,
  output logic        timeout,
  output logic        busy,
  output logic [27:0] seg
);

  localparam int MW = $clog2(HOLD_MS) + 1;
  localparam logic [MW-1:0] MS_LAST = MW'(HOLD_MS - 1);

  // Reject hold and blink periods that could never elapse.
  if (HOLD_MS < 1 || BLINK_MS < 1) begin : g_bad_params
    $error("face_timer_display: HOLD_MS and BLINK_MS must be >= 1");
  end

  state_t        state;
  logic [MW-1:0] ms_cnt;
  logic          counting;
  logic          tick;
  logic          hold_done;
  logic [6:0]    eye_shown;

  // An abort (enable dropped) stops counting in the same cycle, which also
  // gives abort priority over a completing tick.
  assign counting  = (state == COUNT) && timer_enable;
  assign hold_done = tick && (ms_cnt == MS_LAST);

  ms_tick_gen #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(!counting),
    .tick (tick)
  );

  // Handshake FSM with timeout/busy registered alongside the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ms_cnt  <= '0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          ms_cnt <= '0;
          if (timer_enable) begin
            state <= COUNT;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        COUNT: begin
          if (!timer_enable) begin
            state  <= IDLE;
            ms_cnt <= '0;
            busy   <= 1'b0;
          end else if (hold_done) begin
            state   <= DONE;
            ms_cnt  <= '0;
            timeout <= 1'b1;
            busy    <= 1'b1;
          end else if (tick) begin
            ms_cnt <= ms_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= WAIT_LOW;
          busy  <= 1'b1;
        end
        WAIT_LOW: begin
          if (!timer_enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FACE_BLINK_EN
  localparam int BW = $clog2(BLINK_MS) + 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Blink phase toggles every BLINK_MS ticks while counting, zero otherwise.
  always_ff @(posedge clk) begin
    if (!rst || !counting || hold_done) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 1'b1;
      end
    end
  end

  assign eye_shown = blink_phase ? SEG_BLANK : eyes;
`else
  assign eye_shown = eyes;
`endif

  // Registered digit bus: face overlay or the game digits.
  always_ff @(posedge clk) begin
    if (!rst)
      seg <= {4{SEG_BLANK}};
    else if (showFace)
      seg <= {eye_shown, mouth, mouth, eye_shown};
    else
      seg <= game_seg;
  end

endmodule

// File: tb/tb_face_timer_display.sv
// Directed self-checking bench for face_timer_display with small timing
// parameters (4 clk per ms, 3 ms hold, 1 ms blink). Expected values follow
// FACE_BLINK_EN when the bench is built with that macro.
module tb_face_timer_display;

  localparam logic [6:0] BLANK = 7'h7F;

  logic        clk;
  logic        rst;
  logic        timer_enable;
  logic        showFace;
  logic [6:0]  eyes;
  logic [6:0]  mouth;
  logic [27:0] game_seg;
  logic        timeout;
  logic        busy;
  logic [27:0] seg;

  int vectorCount;
  int missCount;

  face_timer_display #(
    .CLK_PER_MS(4),
    .HOLD_MS   (3),
    .BLINK_MS  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .timer_enable(timer_enable),
    .showFace    (showFace),
    .eyes        (eyes),
    .mouth       (mouth),
    .game_seg    (game_seg),
    .timeout     (timeout),
    .busy        (busy),
    .seg         (seg)
  );

  // 10 ns board clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the handshake inputs and advance the given number of clock edges,
  // leaving time 1 ns past the last edge for sampling.
  task automatic applyStimulus(input logic te, input logic sf, input int cycles);
    timer_enable = te;
    showFace     = sf;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [27:0] observed,
                             input logic [27:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Safety net so the run cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0]  expEye;
    logic [27:0] faceSeg;

    vectorCount  = 0;
    missCount    = 0;
    rst          = 1'b0;
    timer_enable = 1'b0;
    showFace     = 1'b0;
    eyes         = 7'b1110110;
    mouth        = 7'b1110000;
    game_seg     = 28'h0123456;

    // 1: reset
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("reset_timeout", {27'd0, timeout}, 28'd0);
    checkOutput("reset_busy", {27'd0, busy}, 28'd0);
    checkOutput("reset_seg", seg, 28'hFFFFFFF);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("idle_busy", {27'd0, busy}, 28'd0);

    // 2: nominal hold, timeout one cycle after edge E0+12
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("nom_busy_e1", {27'd0, busy}, 28'd1);
    for (int k = 2; k <= 11; k++) begin
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("nom_no_early_timeout", {27'd0, timeout}, 28'd0);
    end
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("nom_timeout_e12", {27'd0, timeout}, 28'd1);
    checkOutput("nom_busy_e12", {27'd0, busy}, 28'd1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("nom_timeout_low_e13", {27'd0, timeout}, 28'd0);
    checkOutput("nom_busy_wait", {27'd0, busy}, 28'd1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("nom_busy_idle", {27'd0, busy}, 28'd0);

    // 3: abort after 7 cycles, then a fresh full count
    applyStimulus(1'b1, 1'b0, 7);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("abort_busy", {27'd0, busy}, 28'd0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("abort_no_timeout", {27'd0, timeout}, 28'd0);
    end
    applyStimulus(1'b1, 1'b0, 1);
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("rearm_no_early_timeout", {27'd0, timeout}, 28'd0);
    end
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("rearm_timeout_e12", {27'd0, timeout}, 28'd1);

    // 4: stale enable held after timeout gives no second pulse
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("stale_no_timeout", {27'd0, timeout}, 28'd0);
      checkOutput("stale_busy", {27'd0, busy}, 28'd1);
    end
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("stale_release_busy", {27'd0, busy}, 28'd0);

    // 5: display mux
    checkOutput("mux_game_idle", seg, 28'h0123456);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("mux_face", seg, 28'hEDC3876);
    showFace = 1'b0;
    #2;
    checkOutput("mux_face_held", seg, 28'hEDC3876);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("mux_game", seg, 28'h0123456);

    // 6: face shown during COUNT, blinking only with FACE_BLINK_EN
    applyStimulus(1'b1, 1'b1, 1);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 1'b1, 1);
      expEye = eyes;
`ifdef FACE_BLINK_EN
      if (k >= 5 && k <= 8)
        expEye = BLANK;
`endif
      faceSeg = {expEye, mouth, mouth, expEye};
      checkOutput("blink_seg", seg, faceSeg);
    end
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("blink_after_done", seg, 28'hEDC3876);
    applyStimulus(1'b0, 1'b0, 2);

    // 7: reset mid-COUNT
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("midrst_busy_before", {27'd0, busy}, 28'd1);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("midrst_busy", {27'd0, busy}, 28'd0);
    checkOutput("midrst_timeout", {27'd0, timeout}, 28'd0);
    checkOutput("midrst_seg", seg, 28'hFFFFFFF);
    rst = 1'b1;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("midrst_no_timeout", {27'd0, timeout}, 28'd0);
    end
    checkOutput("midrst_idle_busy", {27'd0, busy}, 28'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
